e203_ifu_bpu_rdport_arb: RTL
============================

Name: e203_ifu_bpu_rdport_arb

Overview:
- Shares the single regfile read port 1 between two requesters: IFU branch predictor (JALR rs1 = xN target fetch) and EXU operand read.
- Sequences the BPU read: grant, capture of the returned data, and hold until the IFU consumes it.
- Provides a bounded-starvation guarantee for the BPU and an IFU-side flush.
- Sits between the IFU lite-BPU and the regfile read mux, alongside the EXU dispatch path.

Parameters:
- RFIDX_W, 5, regfile index width.
- XLEN, 32, data width.
- STARVE_MAX, 3, consecutive cycles the BPU may lose contention before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-high (name kept for codebase consistency).
- bpu_req_vld  in  1  BPU read request.
- bpu_req_idx  in  RFIDX_W  BPU source register index.
- bpu_req_rdy  out  1  BPU request accepted this cycle.
- bpu_rsp_vld  out  1  BPU read data valid, held until consumed.
- bpu_rsp_dat  out  XLEN  BPU read data.
- bpu_rsp_rdy  in  1  IFU consumes bpu_rsp.
- exu_req_vld  in  1  EXU read request.
- exu_req_idx  in  RFIDX_W  EXU source register index.
- exu_req_rdy  out  1  EXU request accepted this cycle.
- exu_rsp_vld  out  1  EXU read data valid; no backpressure.
- exu_rsp_dat  out  XLEN  EXU read data.
- rf_rd_ena  out  1  regfile port-1 read enable.
- rf_rd_idx  out  RFIDX_W  regfile port-1 index.
- rf_rd_dat  in  XLEN  regfile data, valid the cycle after rf_rd_ena.
- flush  in  1  IFU flush; cancels BPU activity only.
- bpu_busy  out  1  BPU transaction outstanding (state != IDLE).

Behaviour:
- Reset state: FSM IDLE, starve_cnt = 0, bpu_rsp_vld = 0, bpu_rsp_dat = 0, exu_rsp_vld = 0, bpu_busy = 0.
- FSM states:
  - IDLE: no BPU transaction.
  - RD: BPU read issued; data arrives this cycle.
  - RSP: data held in bpu_rsp.
- starve_hit = (starve_cnt == STARVE_MAX).
- Grant logic (combinational, at most one grant per cycle):
  - bpu_gnt = IDLE & bpu_req_vld & ~flush & (~exu_req_vld | starve_hit).
  - exu_gnt = exu_req_vld & ~bpu_gnt.
  - bpu_req_rdy = IDLE & ~flush & (~exu_req_vld | starve_hit), independent of bpu_req_vld.
  - exu_req_rdy = ~bpu_gnt.
- Regfile drive:
  - rf_rd_ena = bpu_gnt | exu_gnt.
  - rf_rd_idx = bpu_gnt ? bpu_req_idx : exu_req_idx.
  - x0 is not special-cased.
- starve_cnt update:
  - +1 (saturating at STARVE_MAX) when IDLE & bpu_req_vld & ~flush & exu_gnt.
  - Cleared on bpu_gnt, on flush, or when bpu_req_vld = 0.
- Transitions:
  - IDLE -> RD on bpu_gnt.
  - RD -> RSP; captures rf_rd_dat into bpu_rsp_dat and sets bpu_rsp_vld.
  - RSP -> IDLE on bpu_rsp_rdy.
  - RSP has no zero-wait path; minimum BPU request-to-request spacing is 3 cycles.
- Flush:
  - RD & flush -> IDLE, data discarded, bpu_rsp_vld stays 0.
  - RSP & flush -> IDLE, bpu_rsp_vld cleared next cycle; same-cycle bpu_rsp_rdy is ignored.
- EXU side:
  - exu_rsp_vld = registered exu_gnt.
  - exu_rsp_dat = rf_rd_dat, combinational in the response cycle.
  - EXU may be granted while the FSM is in RD or RSP; the BPU then holds no port.
- Simultaneous requests: EXU wins unless starve_hit; a flush in the same cycle blocks bpu_gnt and lets EXU win.
- Mid-operation reset: returns to IDLE immediately; no response is issued for an in-flight read.

Test Plan:
- Solo BPU read: bpu_req idx=5 (x5=0x8000_0100), no EXU -> rf_rd_ena with idx 5 in cycle 0; bpu_rsp_vld=1, dat=0x8000_0100 from cycle 2; held until bpu_rsp_rdy, then IDLE.
- Contention: EXU requests every cycle, BPU idx=7 continuously, STARVE_MAX=3 -> EXU granted cycles 0-2, BPU granted cycle 3, exu_req_rdy=0 in cycle 3, starve_cnt=0 afterwards.
- Interleave: BPU in RSP with bpu_rsp_rdy=0 for 4 cycles while EXU reads idx 1,2,3,4 -> four exu_rsp_vld with matching data; bpu_rsp_dat unchanged.
- Flush in RD -> no bpu_rsp_vld, FSM IDLE; flush in RSP -> bpu_rsp_vld drops the next cycle.
- Flush coincident with a new BPU request and no EXU -> bpu_req_rdy=0, no rf read; request granted the following cycle.
- Reset asserted in RD -> all outputs at reset values the next cycle; no stale response after deassertion.

Source files
------------

// File: rtl/e203_ifu_bpu_rdport_arb_if.sv
// Bundle of the BPU, EXU and regfile port-1 signals around the read-port arbiter.
// Handshake rules: a request transfers in a cycle where its req_vld and req_rdy
// are both high. bpu_rsp_vld stays high, with stable data, until a cycle with
// bpu_rsp_rdy high or a flush. exu_rsp_vld lasts exactly one cycle and is never
// back-pressured. rf_rd_dat must be valid the cycle after rf_rd_ena.
interface e203_ifu_bpu_rdport_arb_if #(
  parameter int RFIDX_W = 5,
  parameter int XLEN    = 32
);
  logic               bpu_req_vld;
  logic [RFIDX_W-1:0] bpu_req_idx;
  logic               bpu_req_rdy;
  logic               bpu_rsp_vld;
  logic [XLEN-1:0]    bpu_rsp_dat;
  logic               bpu_rsp_rdy;
  logic               exu_req_vld;
  logic [RFIDX_W-1:0] exu_req_idx;
  logic               exu_req_rdy;
  logic               exu_rsp_vld;
  logic [XLEN-1:0]    exu_rsp_dat;
  logic               rf_rd_ena;
  logic [RFIDX_W-1:0] rf_rd_idx;
  logic [XLEN-1:0]    rf_rd_dat;
  logic               flush;
  logic               bpu_busy;

  // Arbiter side.
  modport slave (
    input  bpu_req_vld, bpu_req_idx, bpu_rsp_rdy,
    input  exu_req_vld, exu_req_idx, rf_rd_dat, flush,
    output bpu_req_rdy, bpu_rsp_vld, bpu_rsp_dat,
    output exu_req_rdy, exu_rsp_vld, exu_rsp_dat,
    output rf_rd_ena, rf_rd_idx, bpu_busy
  );

  // Requesters and regfile side.
  modport master (
    output bpu_req_vld, bpu_req_idx, bpu_rsp_rdy,
    output exu_req_vld, exu_req_idx, rf_rd_dat, flush,
    input  bpu_req_rdy, bpu_rsp_vld, bpu_rsp_dat,
    input  exu_req_rdy, exu_rsp_vld, exu_rsp_dat,
    input  rf_rd_ena, rf_rd_idx, bpu_busy
  );
endinterface

// File: rtl/e203_ifu_bpu_rdport_arb.sv
// Shares regfile read port 1 between the IFU lite-BPU (JALR rs1 target read)
// and the EXU operand read. EXU normally wins. After STARVE_MAX consecutive
// losses, the BPU is forced to win. A BPU read returns its data one cycle after
// the grant. That data is held until the IFU consumes it or flushes.
module e203_ifu_bpu_rdport_arb #(
  parameter int RFIDX_W    = 5,
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,       // synchronous, active-high
  e203_ifu_bpu_rdport_arb_if.slave     bus,
  output logic [1:0]                   dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  state_e             state_q, state_d;
  logic [3:0]         starve_cnt_q, starve_cnt_d;
  logic               bpu_rsp_vld_q, bpu_rsp_vld_d;
  logic [XLEN-1:0]    bpu_rsp_dat_q, bpu_rsp_dat_d;
  logic               exu_rsp_vld_q;

  logic               is_idle;
  logic               starve_hit;
  logic               bpu_can_win;
  logic               bpu_gnt;
  logic               exu_gnt;
  logic [RFIDX_W-1:0] rd_idx;

  // Grant decision: one grant per cycle; flush blocks only the BPU.
  always_comb begin
    is_idle     = (state_q == ST_IDLE);
    starve_hit  = (starve_cnt_q == STARVE_MAX_C);
    bpu_can_win = is_idle & ~bus.flush & (~bus.exu_req_vld | starve_hit);
    bpu_gnt     = bpu_can_win & bus.bpu_req_vld;
    exu_gnt     = bus.exu_req_vld & ~bpu_gnt;
    rd_idx      = bpu_gnt ? bus.bpu_req_idx : bus.exu_req_idx;
  end

  assign bus.bpu_req_rdy = bpu_can_win;
  assign bus.exu_req_rdy = ~bpu_gnt;
  assign bus.rf_rd_ena   = bpu_gnt | exu_gnt;
  assign bus.rf_rd_idx   = rd_idx;
  assign bus.bpu_rsp_vld = bpu_rsp_vld_q;
  assign bus.bpu_rsp_dat = bpu_rsp_dat_q;
  assign bus.exu_rsp_vld = exu_rsp_vld_q;
  // The EXU result is taken straight from the regfile in the response cycle.
  assign bus.exu_rsp_dat = bus.rf_rd_dat;
  assign bus.bpu_busy    = ~is_idle;
  assign dbg_state_o     = state_q;

  // Next-state logic for the BPU transaction FSM, its response register and the starvation counter.
  always_comb begin
    state_d       = state_q;
    bpu_rsp_vld_d = bpu_rsp_vld_q;
    bpu_rsp_dat_d = bpu_rsp_dat_q;
    starve_cnt_d  = starve_cnt_q;

    // Count only real losses by a waiting, idle BPU. Any grant, flush or
    // withdrawn request restarts the count.
    if (bpu_gnt | bus.flush | ~bus.bpu_req_vld) begin
      starve_cnt_d = 4'd0;
    end else if (is_idle & exu_gnt & ~starve_hit) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bpu_gnt) state_d = ST_RD;
      end
      ST_RD: begin
        // On a flush the returning data is dropped, and the old response stays as it was.
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d       = ST_RSP;
          bpu_rsp_vld_d = 1'b1;
          bpu_rsp_dat_d = bus.rf_rd_dat;
        end
      end
      ST_RSP: begin
        if (bus.flush | bus.bpu_rsp_rdy) begin
          state_d       = ST_IDLE;
          bpu_rsp_vld_d = 1'b0;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        bpu_rsp_vld_d = 1'b0;
      end
    endcase
  end

  // State and response registers; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q       <= ST_IDLE;
      starve_cnt_q  <= 4'd0;
      bpu_rsp_vld_q <= 1'b0;
      bpu_rsp_dat_q <= '0;
      exu_rsp_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      bpu_rsp_vld_q <= bpu_rsp_vld_d;
      bpu_rsp_dat_q <= bpu_rsp_dat_d;
      exu_rsp_vld_q <= exu_gnt;
    end
  end

endmodule
